// File: rtl/uc_multiciclo_if.sv
// Control bundle between the multicycle control unit and the RV64 datapath:
// opcode comes back from IR, every enable and mux select goes out.
interface uc_multiciclo_if;
    logic [6:0] opcode;
    logic [1:0] aluop;
    logic       Mux1;
    logic [1:0] Mux2;
    logic       Mux4;
    logic       jump;
    logic       weMem;
    logic       weReg;
    logic       weIR;
    logic       wePc;

    modport master (
        input  opcode,
        output aluop, Mux1, Mux2, Mux4, jump, weMem, weReg, weIR, wePc
    );

    modport slave (
        output opcode,
        input  aluop, Mux1, Mux2, Mux4, jump, weMem, weReg, weIR, wePc
    );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the RV64 datapath: registered state, outputs decoded
// combinationally from state and opcode, with run control, halt and retire counter.
module uc_multiciclo #(
    parameter int MAX_INSTR = 0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    uc_multiciclo_if.master  dp,
    output logic [3:0]       state_reg,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB     = 4'd6,
        BRANCH = 4'd7,
        JUMP   = 4'd8,
        HALT   = 4'd9
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t           cur_state_reg;
    state_t           state_next;
    state_t           retire_next;
    logic [CNT_W-1:0] instret_reg;

    logic [1:0] aluop;
    logic       mux1;
    logic [1:0] mux2;
    logic       mux4;
    logic       jump;
    logic       we_mem;
    logic       we_reg;
    logic       we_ir;
    logic       we_pc;

    logic is_alu;
    logic is_load;
    logic is_store;
    logic is_jump;
    logic budget_hit;

    assign is_alu   = (dp.opcode == OP_R) || (dp.opcode == OP_I);
    assign is_load  = (dp.opcode == OP_LD);
    assign is_store = (dp.opcode == OP_ST);
    assign is_jump  = (dp.opcode == OP_JAL) || (dp.opcode == OP_JALR);

    // The retiring edge is the one that would make instret equal the budget.
    assign budget_hit  = (MAX_INSTR != 0) &&
                         ((instret_reg + CNT_W'(1)) == CNT_W'(MAX_INSTR));
    assign retire_next = budget_hit ? HALT : (stop ? IDLE : FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state_reg <= IDLE;
        end else begin
            cur_state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_reg <= '0;
        end else if (we_pc) begin
            instret_reg <= instret_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = cur_state_reg;
        aluop      = 2'b00;
        mux1       = 1'b0;
        mux2       = 2'b00;
        mux4       = 1'b0;
        jump       = 1'b0;
        we_mem     = 1'b0;
        we_reg     = 1'b0;
        we_ir      = 1'b0;
        we_pc      = 1'b0;

        case (cur_state_reg)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                we_ir      = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (is_alu || is_load || is_store) state_next = EXEC;
                else if (dp.opcode == OP_BR)       state_next = BRANCH;
                else if (is_jump)                  state_next = JUMP;
                else                               state_next = HALT;
            end
            EXEC: begin
                aluop = is_alu ? 2'b10 : 2'b00;
                mux1  = (dp.opcode != OP_R);
                // An opcode that changed under us since DECODE is treated as illegal.
                if (is_alu)        state_next = WB;
                else if (is_load)  state_next = MEM_RD;
                else if (is_store) state_next = MEM_WR;
                else               state_next = HALT;
            end
            MEM_RD: begin
                mux1       = 1'b1;
                state_next = WB;
            end
            MEM_WR: begin
                mux1       = 1'b1;
                we_mem     = 1'b1;
                we_pc      = 1'b1;
                state_next = retire_next;
            end
            WB: begin
                aluop      = is_alu ? 2'b10 : 2'b00;
                mux1       = (dp.opcode != OP_R);
                mux2       = is_load ? 2'b00 : 2'b01;
                we_reg     = 1'b1;
                we_pc      = 1'b1;
                state_next = retire_next;
            end
            BRANCH: begin
                aluop      = 2'b01;
                mux4       = 1'b1;
                we_pc      = 1'b1;
                state_next = retire_next;
            end
            JUMP: begin
                mux2       = 2'b10;
                mux4       = (dp.opcode == OP_JAL);
                jump       = 1'b1;
                we_reg     = 1'b1;
                we_pc      = 1'b1;
                state_next = retire_next;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    assign dp.aluop = aluop;
    assign dp.Mux1  = mux1;
    assign dp.Mux2  = mux2;
    assign dp.Mux4  = mux4;
    assign dp.jump  = jump;
    assign dp.weMem = we_mem;
    assign dp.weReg = we_reg;
    assign dp.weIR  = we_ir;
    assign dp.wePc  = we_pc;

    assign state_reg = cur_state_reg;
    assign halted    = (cur_state_reg == HALT);
    assign instret   = instret_reg;

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multicycle control unit sequencing the RV64 datapath: register file, ALU, data memory, PC, IR, and Mux1/Mux2/Mux4.
- Fuses the state register and the output decode into one block.
- Adds start/stop run control, illegal-opcode halt, a retired-instruction counter and an optional instruction budget.
- Sits beside the datapath. Consumes `opcode` from IR; drives every write enable and mux select.

Parameters:
- `MAX_INSTR`, 0: halt after this many retired instructions; 0 = unlimited.
- `CNT_W`, 32: width of `instret`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; leave IDLE and begin fetching.
- `stop`  in  1  level; finish the current instruction, then return to IDLE.
- `opcode`  in  7  `IR[6:0]`; valid from DECODE onward.
- `aluop`  out  2  00 add, 01 branch compare, 10 funct-decoded.
- `Mux1`  out  1  ALU b input: 0 `doutB`, 1 `imm`.
- `Mux2`  out  2  register write data: 00 mem `dout`, 01 ALU `soma`, 10 `PC_four`, 11 `PC_imm`.
- `Mux4`  out  1  PC-adder base: 0 `doutA`, 1 `PC`.
- `jump`  out  1  forces Mux3 to the PC+imm path; ORed with ALU `flag` at integration.
- `weMem`  out  1  data memory write.
- `weReg`  out  1  register file write.
- `weIR`  out  1  IR load.
- `wePc`  out  1  PC load.
- `state_reg`  out  4  current state code.
- `halted`  out  1  high in HALT.
- `instret`  out  `CNT_W`  retired-instruction count.

Behaviour:
- **Reset** (async, `reset`=0):
  - `state_reg` = IDLE (0).
  - `instret` = 0.
  - All enables, `jump` and `halted` = 0.
  - `aluop`, `Mux1`, `Mux2`, `Mux4` = 0.
  - Reset asserted mid-instruction aborts it immediately; no enable survives the reset edge.
- **State codes:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM_RD=4, MEM_WR=5, WB=6, BRANCH=7, JUMP=8, HALT=9. Codes 10–15 are unreachable and go to HALT.
- **Output timing:** registered state; outputs are combinational from `state_reg` and `opcode`. Any signal not listed for a state is 0.
- **IDLE:** go to FETCH when `start`=1, else stay.
- **FETCH:** `weIR`=1; next state DECODE.
- **DECODE:** no enables. Next state by `opcode`:
  - 0110011 (R), 0010011 (I-ALU), 0000011 (load), 0100011 (store) → EXEC.
  - 1100011 → BRANCH.
  - 1101111, 1100111 → JUMP.
  - Any other → HALT.
- **EXEC:**
  - R: `aluop`=10, `Mux1`=0 → WB.
  - I-ALU: `aluop`=10, `Mux1`=1 → WB.
  - Load: `aluop`=00, `Mux1`=1 → MEM_RD.
  - Store: `aluop`=00, `Mux1`=1 → MEM_WR.
- **MEM_RD:** `aluop`=00, `Mux1`=1 (address held) → WB.
- **MEM_WR:** `aluop`=00, `Mux1`=1, `weMem`=1, `wePc`=1. Retires the instruction.
- **WB:** `weReg`=1, `wePc`=1. Retires the instruction. ALU operand selects are held as in EXEC.
  - Load: `Mux2`=00.
  - Otherwise: `Mux2`=01.
- **BRANCH:** `aluop`=01, `Mux1`=0, `Mux4`=1, `wePc`=1. Retires the instruction; the ALU `flag` picks PC+4 or PC+imm.
- **JUMP:** `weReg`=1, `Mux2`=10, `jump`=1, `wePc`=1. Retires the instruction.
  - JAL: `Mux4`=1.
  - JALR: `Mux4`=0.
- **After a retiring state:** next state is
  - HALT if the budget is reached: `MAX_INSTR`≠0 and `instret`+1 == `MAX_INSTR`;
  - else IDLE if `stop`=1;
  - else FETCH.
- **Stop sampling:** `stop` is sampled only in retiring states. Stop asserted earlier is ignored unless it is still high at retirement.
- **HALT:** `halted`=1, all enables 0. Only reset leaves HALT; `start` is ignored.
- **Counter:** `instret` increments by 1 on every clock edge where `wePc`=1. It wraps modulo 2^`CNT_W`; the wrap does not halt.
- **Cycles per instruction:** R/I-ALU 4, load 5, store 4, branch 3, jal/jalr 3.
- **`start` and `stop` both high in IDLE:** `start` wins; one instruction runs, then return to IDLE.

Test Plan:
- **Reset then run:** release `reset` with `start`=0 → `state_reg` stays 0 and all enables 0 for 5 cycles. Then `start`=1 → next edge `state_reg`=1, `weIR`=1.
- **R-type:** add (opcode 0110011) then sub.
  - `state_reg` sequence 1,2,3,6,1,2,3,6.
  - `weReg`=1 and `Mux2`=01 only in state 6.
  - `instret` = 2 after 8 cycles.
- **Load then store:**
  - Load: sequence 1,2,3,4,6; `Mux2`=00 in WB.
  - Store: sequence 1,2,3,5; `weMem`=1 for exactly 1 cycle.
  - `instret` = 2.
- **Branch and jumps:**
  - Branch: sequence 1,2,7; `aluop`=01, `Mux4`=1, `wePc`=1 in 7.
  - JAL: `jump`=1, `Mux2`=10, `Mux4`=1 in 8.
  - JALR: `Mux4`=0.
- **Illegal opcode and budget:**
  - Opcode 1111111 → DECODE goes to 9, `halted`=1; stays there with `start`=1 until reset.
  - `MAX_INSTR`=3 → halts after the third WB with `instret`=3.
- **Stop and mid-run reset:**
  - `stop` pulsed during EXEC and dropped before WB → continues to FETCH.
  - `stop` held through WB → returns to IDLE.
  - `reset` low during MEM_WR → `weMem` drops immediately, `state_reg`=0, `instret`=0.
